// File: rtl/scramble_sequencer_pkg.sv
// Shared types and constants for the scramble move generator and its random source.
package scramble_sequencer_pkg;

  typedef enum logic [2:0] {IDLE, SELECT, FIRE, GAP, DONE} state_t;

  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam int          GRID_N       = 4;

  typedef struct packed {
    logic       x_nrow;
    logic [1:0] idx;
  } move_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

  // Candidate line move drawn from the low bits of the random word.
  function automatic move_t cand_of(input logic [15:0] v);
    return '{x_nrow: v[2], idx: v[1:0]};
  endfunction

endpackage

// File: rtl/scramble_sequencer_if.sv
// Request/move bus between the scramble sequencer and the cell array mux.
interface scramble_sequencer_if;
  import scramble_sequencer_pkg::*;

  logic              start;
  logic              abort;
  logic              fire;
  logic              x_nRow;
  logic [GRID_N-1:0] row_column;
  logic              busy;
  logic              done;
  logic [7:0]        moves_left;

  modport master (input start, abort,
                  output fire, x_nRow, row_column, busy, done, moves_left);
  modport slave  (output start, abort,
                  input fire, x_nRow, row_column, busy, done, moves_left);
endinterface

// File: rtl/scramble_sequencer_lfsr16.sv
// 16-bit Galois LFSR, free-running; a zero seed falls back to the default seed.
module lfsr16
  import scramble_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] out
);

    logic [15:0] seed_eff;
    assign seed_eff = (seed == 16'h0000) ? DEFAULT_SEED : seed;

    always_ff @(posedge clk) begin
        if (reset) out <= seed_eff;
        else       out <= lfsr_next(out);
    end

endmodule

// File: rtl/scramble_sequencer.sv
// Issues NUM_MOVES paced pseudo-random line moves per start, never repeating a line back-to-back.
module scramble_sequencer
  import scramble_sequencer_pkg::*;
#(
    parameter int          NUM_MOVES   = 16,
    parameter int          PACE_CYCLES = 16,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    scramble_sequencer_if.master  bus
);

    localparam int CW = $clog2(PACE_CYCLES + 1);

    state_t            state, state_nx;
    logic [15:0]       lfsr;
    move_t             cand, prev_q;
    logic              prev_vld;
    logic [GRID_N-1:0] rc_q;
    logic              xn_q;
    logic [CW-1:0]     gap_cnt;
    logic [7:0]        left_q;
    logic              repeat_hit, gap_end, busy;

    lfsr16 u_lfsr (.clk(clk), .reset(reset), .seed(LFSR_SEED), .out(lfsr));

    assign cand       = cand_of(lfsr);
    assign repeat_hit = prev_vld && (cand == prev_q);
    assign gap_end    = (gap_cnt == '0);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = SELECT;
            SELECT:  if (!repeat_hit) state_nx = FIRE;
            FIRE:    state_nx = GAP;
            GAP:     if (gap_end) state_nx = (left_q == 8'd0) ? DONE : SELECT;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // abort outranks start, including a start seen in IDLE
        if (bus.abort) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            prev_q   <= '0;
            prev_vld <= 1'b0;
            rc_q     <= '0;
            xn_q     <= 1'b0;
            gap_cnt  <= '0;
            left_q   <= 8'd0;
        end else begin
            state <= state_nx;
            if (bus.abort || state == DONE) begin
                prev_vld <= 1'b0;
                rc_q     <= '0;
                xn_q     <= 1'b0;
                left_q   <= 8'd0;
            end else begin
                case (state)
                    IDLE: if (bus.start) left_q <= 8'(NUM_MOVES);
                    SELECT: if (!repeat_hit) begin
                        rc_q     <= {{(GRID_N-1){1'b0}}, 1'b1} << cand.idx;
                        xn_q     <= cand.x_nrow;
                        prev_q   <= cand;
                        prev_vld <= 1'b1;
                    end
                    FIRE: begin
                        if (left_q != 8'd0) left_q <= left_q - 8'd1;
                        gap_cnt <= CW'(PACE_CYCLES - 1);
                    end
                    GAP: if (!gap_end) gap_cnt <= gap_cnt - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign busy           = (state == SELECT) || (state == FIRE) || (state == GAP);
    assign bus.busy       = busy;
    assign bus.fire       = (state == FIRE) && !bus.abort;
    assign bus.done       = (state == DONE);
    assign bus.row_column = busy ? rc_q : '0;
    assign bus.x_nRow     = busy & xn_q;
    assign bus.moves_left = left_q;

endmodule
